// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the branch-resolve controller: the tracked-branch record,
// the controller state encoding and the mispredict test.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic       pred_taken;
        word_t      pred_target;
        word_t      npc;
        logic [1:0] index;
    } br_rec_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } brc_state_t;

    // A taken branch is only correct when the predicted target matches exactly.
    function automatic logic br_mispredict(input br_rec_t rec, input logic taken,
                                           input word_t target);
        return (rec.pred_taken != taken) || (taken && (rec.pred_target != target));
    endfunction

endpackage

// File: rtl/br_track_fifo.sv
// In-order queue of in-flight branch records; accepts a push while full when a
// pop happens in the same cycle. Clear wins over push and pop.
module br_track_fifo
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_push,
    input  br_rec_t i_push_data,
    input  logic    i_pop,
    input  logic    i_clear,
    output br_rec_t o_head,
    output logic    o_full,
    output logic    o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    br_rec_t     r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/br_resolve_ctrl.sv
// Branch-predictor resolve controller: tracks predictions, issues predictor
// updates and flush/redirect on mispredict. Optional stats: BR_RESOLVE_STATS_EN.
module br_resolve_ctrl
    import cpu_types_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        if_push,
    input  logic        if_pred_taken,
    input  logic [31:0] if_pred_target,
    input  logic [31:0] if_npc,
    input  logic [1:0]  if_index,
    input  logic        ex_resolve,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        upd_en,
    output logic        upd_taken,
    output logic [31:0] upd_target,
    output logic [1:0]  upd_index,
    output logic        upd_correct,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        fetch_stall,
    output logic        proto_err
`ifdef BR_RESOLVE_STATS_EN
    ,
    output logic [31:0] stat_resolved,
    output logic [31:0] stat_mispred
`endif
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    brc_state_t  r_state;
    logic [CW-1:0] r_flush_cnt;

    br_rec_t w_head;
    br_rec_t w_push_rec;
    logic    w_full;
    logic    w_empty;
    logic    w_run;
    logic    w_pop;
    logic    w_push;
    logic    w_mispred;
    logic    w_mis_pop;
    logic    w_err;

    assign w_run      = (r_state == RUN);
    assign w_pop      = ex_resolve && !w_empty && w_run;
    assign w_err      = ex_resolve && w_empty && w_run;
    assign w_mispred  = br_mispredict(w_head, ex_taken, ex_target);
    assign w_mis_pop  = w_pop && w_mispred;
    // A mispredict clears the queue on this edge, so a same-cycle push is discarded.
    assign w_push     = if_push && w_run && (!w_full || w_pop) && !w_mis_pop;
    assign w_push_rec = '{pred_taken:  if_pred_taken,
                          pred_target: if_pred_target,
                          npc:         if_npc,
                          index:       if_index};

    assign fetch_stall = w_full || !w_run;

    br_track_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk       (CLK),
        .i_rst_n     (nRST),
        .i_push      (w_push),
        .i_push_data (w_push_rec),
        .i_pop       (w_pop),
        .i_clear     (w_mis_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
            upd_en      <= 1'b0;
            upd_taken   <= 1'b0;
            upd_target  <= '0;
            upd_index   <= '0;
            upd_correct <= 1'b0;
            flush       <= 1'b0;
            redirect_pc <= '0;
            proto_err   <= 1'b0;
        end else begin
            upd_en      <= w_pop;
            upd_taken   <= w_pop && ex_taken;
            upd_index   <= w_pop ? w_head.index : '0;
            upd_target  <= !w_pop ? '0 : (ex_taken ? ex_target : w_head.pred_target);
            upd_correct <= w_pop && !w_mispred;
            flush       <= w_mis_pop;
            redirect_pc <= !w_mis_pop ? '0 : (ex_taken ? ex_target : w_head.npc);
            if (w_err) proto_err <= 1'b1;

            case (r_state)
                RUN: begin
                    if (w_mis_pop) begin
                        r_state     <= FLUSH;
                        r_flush_cnt <= CW'(FLUSH_CYCLES - 1);
                    end
                end
                FLUSH: begin
                    if (r_flush_cnt == '0) r_state <= RUN;
                    else r_flush_cnt <= r_flush_cnt - CW'(1);
                end
                default: r_state <= RUN;
            endcase
        end
    end

`ifdef BR_RESOLVE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_resolved <= '0;
            stat_mispred  <= '0;
        end else if (upd_en) begin
            if (stat_resolved != '1) stat_resolved <= stat_resolved + 32'd1;
            if (!upd_correct && stat_mispred != '1) stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Scoreboard bench for br_resolve_ctrl: a bench-side queue model predicts each
// update/flush pulse, which is checked when the DUT emits it.
module tb_br_resolve_ctrl;
    import cpu_types_pkg::*;

    localparam int DEPTH = 4;
    localparam int FC    = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        if_push = 1'b0;
    logic        if_pred_taken = 1'b0;
    logic [31:0] if_pred_target = '0;
    logic [31:0] if_npc = '0;
    logic [1:0]  if_index = '0;
    logic        ex_resolve = 1'b0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        upd_en, upd_taken, upd_correct, flush, fetch_stall, proto_err;
    logic [31:0] upd_target, redirect_pc;
    logic [1:0]  upd_index;
`ifdef BR_RESOLVE_STATS_EN
    logic [31:0] stat_resolved, stat_mispred;
`endif

    br_resolve_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
        .CLK(CLK), .nRST(nRST),
        .if_push(if_push), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .if_npc(if_npc), .if_index(if_index),
        .ex_resolve(ex_resolve), .ex_taken(ex_taken), .ex_target(ex_target),
        .upd_en(upd_en), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_index(upd_index), .upd_correct(upd_correct),
        .flush(flush), .redirect_pc(redirect_pc),
        .fetch_stall(fetch_stall), .proto_err(proto_err)
`ifdef BR_RESOLVE_STATS_EN
        , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic [1:0]  idx;
        logic        correct;
        logic        flush;
        logic [31:0] redir;
    } exp_t;

    exp_t    sbq[$];
    br_rec_t m_q[$];
    int      m_flush = 0;
    logic    m_err = 1'b0;
    int      n_cmp = 0;
    int      n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (nRST) begin
            if (upd_en) begin
                if (sbq.size() == 0) begin
                    chk("upd_unexpected", 32'(upd_en), 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("upd_taken",   32'(upd_taken),   32'(e.taken));
                    chk("upd_target",  upd_target,       e.target);
                    chk("upd_index",   32'(upd_index),   32'(e.idx));
                    chk("upd_correct", 32'(upd_correct), 32'(e.correct));
                    chk("flush",       32'(flush),       32'(e.flush));
                    chk("redirect_pc", redirect_pc,      e.redir);
                end
            end else begin
                if (sbq.size() != 0) begin
                    void'(sbq.pop_front());
                    chk("upd_missing", 32'(upd_en), 32'd1);
                end
                chk("flush_idle",    32'(flush),  32'd0);
                chk("redirect_idle", redirect_pc, 32'd0);
            end
        end
    end

    // One clock of stimulus; the model decides acceptance and expected pulses.
    task automatic cyc(input logic push, input logic pt, input logic [31:0] ptg,
                       input logic [31:0] npc, input logic [1:0] idx,
                       input logic res, input logic et, input logic [31:0] etg);
        logic run, mis, have;
        exp_t e;
        br_rec_t r;
        chk("fetch_stall", 32'(fetch_stall), 32'((m_q.size() == DEPTH) || (m_flush > 0)));
        chk("proto_err",   32'(proto_err),   32'(m_err));
        if_push = push; if_pred_taken = pt; if_pred_target = ptg; if_npc = npc; if_index = idx;
        ex_resolve = res; ex_taken = et; ex_target = etg;
        run = (m_flush == 0);
        mis = 1'b0;
        have = 1'b0;
        if (res && run && m_q.size() > 0) begin
            r = m_q.pop_front();
            mis = (r.pred_taken != et) || (et && r.pred_target != etg);
            e.taken = et;
            e.target = et ? etg : r.pred_target;
            e.idx = r.index;
            e.correct = !mis;
            e.flush = mis;
            e.redir = mis ? (et ? etg : r.npc) : 32'd0;
            have = 1'b1;
        end else if (res && run) begin
            m_err = 1'b1;
        end
        if (push && run && !mis && m_q.size() < DEPTH)
            m_q.push_back('{pred_taken: pt, pred_target: ptg, npc: npc, index: idx});
        if (!run) m_flush--;
        if (mis) begin
            m_q.delete();
            m_flush = FC;
        end
        @(posedge CLK);
        if (have) sbq.push_back(e);
        #1;
    endtask

    task automatic push_rec(input logic pt, input logic [31:0] ptg, input logic [31:0] npc,
                            input logic [1:0] idx);
        cyc(1'b1, pt, ptg, npc, idx, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic resolve(input logic et, input logic [31:0] etg);
        cyc(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b1, et, etg);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_upd_en"},      32'(upd_en),      32'd0);
        chk({tag, "_flush"},       32'(flush),       32'd0);
        chk({tag, "_redirect"},    redirect_pc,      32'd0);
        chk({tag, "_upd_target"},  upd_target,       32'd0);
        chk({tag, "_fetch_stall"}, 32'(fetch_stall), 32'd0);
        chk({tag, "_proto_err"},   32'(proto_err),   32'd0);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check_zero_outputs("reset");
        nRST = 1'b1;
        idle(1);

        push_rec(1'b1, 32'h100, 32'h44, 2'd1);
        resolve(1'b1, 32'h100);
        idle(1);

        // Not-taken prediction resolved taken: redirect to the actual target.
        push_rec(1'b0, 32'h0, 32'h2C, 2'd2);
        resolve(1'b1, 32'h80);
        idle(3);

        // Correct direction, wrong target.
        push_rec(1'b1, 32'h200, 32'h48, 2'd3);
        resolve(1'b1, 32'h240);
        idle(3);

        for (int i = 0; i < DEPTH; i++)
            push_rec(1'b1, 32'h300 + 32'(i * 4), 32'h60 + 32'(i * 4), 2'(i));
        push_rec(1'b1, 32'h3F0, 32'h70, 2'd0);
        cyc(1'b1, 1'b1, 32'h3E0, 32'h74, 2'd2, 1'b1, m_q[0].pred_taken, m_q[0].pred_target);
        for (int i = 0; i < DEPTH; i++) begin
            br_rec_t h;
            h = m_q[0];
            resolve(h.pred_taken, h.pred_target);
        end
        idle(1);

        // Mispredicting the oldest of three drops the two younger records.
        push_rec(1'b0, 32'h0, 32'h500, 2'd1);
        push_rec(1'b1, 32'h600, 32'h504, 2'd2);
        push_rec(1'b1, 32'h700, 32'h508, 2'd3);
        resolve(1'b1, 32'h900);
        idle(3);
        resolve(1'b1, 32'h600);
        idle(2);
        cyc(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b1, 1'b0, 32'd0);
        idle(1);

        // Reset while the flush pulse is on the outputs.
        push_rec(1'b1, 32'hA00, 32'h80, 2'd0);
        resolve(1'b0, 32'd0);
        chk("pre_reset_flush", 32'(flush), 32'd1);
        nRST = 1'b0;
        #1;
        check_zero_outputs("midflush_reset");
        sbq.delete();
        m_q.delete();
        m_flush = 0;
        m_err = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        idle(1);
        push_rec(1'b0, 32'h0, 32'h90, 2'd2);
        resolve(1'b0, 32'hDEAD);
        idle(2);

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
